// File: rtl/sdram_pkg.sv
// Shared SDRAM controller constants.
// Command encodings are {cs_n,ras_n,cas_n,we_n}.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_ARBIT = 3'd1;
    localparam logic [2:0] ST_AREF  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

    localparam int BUSY_W = 10;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM command bus arbiter: grants the pins to init,
// refresh, write or read, with a busy watchdog.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int BUSY_MAX = 1023
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    input  logic        flag_init_end,
    input  logic        ref_req,
    output logic        ref_en,
    input  logic        flag_ref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    input  logic        rd_req,
    output logic        wr_en,
    output logic        rd_en,
    input  logic        flag_wr_end,
    input  logic        flag_rd_end,
    input  logic [3:0]  wr_cmd,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] wr_addr,
    input  logic [12:0] rd_addr,
    input  logic [1:0]  wr_bank,
    input  logic [1:0]  rd_bank,
    input  logic [15:0] wr_data,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [12:0] sdram_addr,
    output logic [1:0]  sdram_bank,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    output logic        busy_err
);

    logic [2:0]        state_q, state_d;
    logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
    logic              busy_err_q, busy_err_d;
    logic              cke_q;
    logic              end_flag;
    logic [3:0]        cmd;

    // Fixed-priority grant pulses, only while idle in ARBIT.
    always_comb begin
        ref_en = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        if (state_q == ST_ARBIT) begin
            if (ref_req)     ref_en = 1'b1;
            else if (wr_req) wr_en  = 1'b1;
            else if (rd_req) rd_en  = 1'b1;
        end
    end

    // Only the end flag of the client holding the bus counts.
    always_comb begin
        end_flag = 1'b0;
        case (state_q)
            ST_AREF:  end_flag = flag_ref_end;
            ST_WRITE: end_flag = flag_wr_end;
            ST_READ:  end_flag = flag_rd_end;
            default:  end_flag = 1'b0;
        endcase
    end

    // Next state, watchdog count and abort strobe.
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = '0;
        busy_err_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (flag_init_end) state_d = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (ref_en)     state_d = ST_AREF;
                else if (wr_en) state_d = ST_WRITE;
                else if (rd_en) state_d = ST_READ;
            end
            ST_AREF, ST_WRITE, ST_READ: begin
                if (end_flag) begin
                    state_d = ST_ARBIT;
                end else if (busy_cnt_q == BUSY_W'(BUSY_MAX)) begin
                    state_d    = ST_ARBIT;
                    busy_err_d = 1'b1;
                end else begin
                    busy_cnt_d = busy_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State, watchdog and clock-enable registers.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q    <= ST_INIT;
            busy_cnt_q <= '0;
            busy_err_q <= 1'b0;
            cke_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            busy_err_q <= busy_err_d;
            cke_q      <= 1'b1;
        end
    end

    // Pin mux: NOP until the first clock out of reset.
    always_comb begin
        cmd          = CMD_NOP;
        sdram_addr   = '0;
        sdram_bank   = '0;
        sdram_dq_oe  = 1'b0;
        sdram_dq_out = '0;
        if (cke_q) begin
            case (state_q)
                ST_INIT: begin
                    cmd        = init_cmd;
                    sdram_addr = init_addr;
                end
                ST_AREF: begin
                    cmd        = aref_cmd;
                    sdram_addr = aref_addr;
                end
                ST_WRITE: begin
                    cmd          = wr_cmd;
                    sdram_addr   = wr_addr;
                    sdram_bank   = wr_bank;
                    sdram_dq_oe  = 1'b1;
                    sdram_dq_out = wr_data;
                end
                ST_READ: begin
                    cmd        = rd_cmd;
                    sdram_addr = rd_addr;
                    sdram_bank = rd_bank;
                end
                default: cmd = CMD_NOP;
            endcase
        end
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_cke = cke_q;
    assign busy_err  = busy_err_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: directed scenarios
// plus randomized traffic against a bus-ownership model.
module tb_sdram_arbit;

    localparam int BMAX = 8;
    localparam int O_INIT = 0;
    localparam int O_IDLE = 1;
    localparam int O_REF  = 2;
    localparam int O_WR   = 3;
    localparam int O_RD   = 4;
    localparam logic [3:0] NOP = 4'b0111;

    logic        sclk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic [3:0]  init_cmd = 4'b0010, aref_cmd = '0;
    logic [3:0]  wr_cmd = '0, rd_cmd = '0;
    logic [12:0] init_addr = '0, aref_addr = '0;
    logic [12:0] wr_addr = '0, rd_addr = '0;
    logic        flag_init_end = 1'b0, ref_req = 1'b0;
    logic        flag_ref_end = 1'b0, wr_req = 1'b0;
    logic        rd_req = 1'b0, flag_wr_end = 1'b0;
    logic        flag_rd_end = 1'b0;
    logic [1:0]  wr_bank = '0, rd_bank = '0;
    logic [15:0] wr_data = '0;

    logic        ref_en, wr_en, rd_en, sdram_cke;
    logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_bank;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe, busy_err;

    wire [3:0] pin_cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    wire [2:0] en = {ref_en, wr_en, rd_en};

    int vecs = 0;
    int errs = 0;

    // Reference model: who owns the bus and for how long.
    int m_own  = O_INIT;
    int m_held = 0;
    bit m_up   = 1'b0;
    bit m_err  = 1'b0;

    logic [3:0]  e_cmd;
    logic [12:0] e_addr;
    logic [1:0]  e_bank;
    logic        e_oe;
    logic [15:0] e_dq;
    logic [2:0]  e_en;

    sdram_arbit #(.BUSY_MAX(BMAX)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .flag_init_end(flag_init_end),
        .ref_req(ref_req), .ref_en(ref_en),
        .flag_ref_end(flag_ref_end),
        .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .rd_req(rd_req),
        .wr_en(wr_en), .rd_en(rd_en),
        .flag_wr_end(flag_wr_end), .flag_rd_end(flag_rd_end),
        .wr_cmd(wr_cmd), .rd_cmd(rd_cmd),
        .wr_addr(wr_addr), .rd_addr(rd_addr),
        .wr_bank(wr_bank), .rd_bank(rd_bank),
        .wr_data(wr_data),
        .sdram_cke(sdram_cke),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
        .busy_err(busy_err)
    );

    always #5 sclk = ~sclk;

    // Expected pins from current owner and live inputs.
    function automatic void expect_pins();
        e_cmd = NOP; e_addr = '0; e_bank = '0;
        e_oe = 1'b0; e_dq = '0; e_en = '0;
        if (m_up) begin
            case (m_own)
                O_INIT: begin e_cmd = init_cmd; e_addr = init_addr; end
                O_REF:  begin e_cmd = aref_cmd; e_addr = aref_addr; end
                O_WR: begin
                    e_cmd = wr_cmd; e_addr = wr_addr; e_bank = wr_bank;
                    e_oe = 1'b1; e_dq = wr_data;
                end
                O_RD: begin e_cmd = rd_cmd; e_addr = rd_addr; e_bank = rd_bank; end
                default: ;
            endcase
        end
        if (m_own == O_IDLE)
            e_en = ref_req ? 3'b100 : wr_req ? 3'b010 : rd_req ? 3'b001 : 3'b000;
    endfunction

    // Advance one clock and update ownership from the sampled inputs.
    task automatic tick();
        bit ended;
        @(posedge sclk);
        if (!s_rst_n) begin
            m_own = O_INIT; m_up = 1'b0; m_err = 1'b0; m_held = 0;
        end else begin
            m_up = 1'b1;
            m_err = 1'b0;
            case (m_own)
                O_INIT: if (flag_init_end) m_own = O_IDLE;
                O_IDLE: begin
                    m_held = 0;
                    if (ref_req)     m_own = O_REF;
                    else if (wr_req) m_own = O_WR;
                    else if (rd_req) m_own = O_RD;
                end
                default: begin
                    ended = (m_own == O_REF && flag_ref_end) ||
                            (m_own == O_WR && flag_wr_end) ||
                            (m_own == O_RD && flag_rd_end);
                    if (ended) begin
                        m_own = O_IDLE; m_held = 0;
                    end else if (m_held == BMAX) begin
                        m_own = O_IDLE; m_err = 1'b1; m_held = 0;
                    end else begin
                        m_held++;
                    end
                end
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        init_cmd = 4'b0010;
        init_addr = 13'h0400;
        #2;
        vecs++;
        if ({sdram_cke, pin_cmd, sdram_addr, sdram_dq_oe, sdram_dq_out, busy_err, en}
            !== {1'b0, NOP, 13'h0, 1'b0, 16'h0, 1'b0, 3'b000}) begin
            errs++;
            $display("FAIL reset_state: cke=%b cmd=%b addr=%h oe=%b dq=%h err=%b en=%b want cke=0 cmd=0111 rest 0",
                     sdram_cke, pin_cmd, sdram_addr, sdram_dq_oe, sdram_dq_out, busy_err, en);
        end
        @(negedge sclk);
        s_rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge sclk);
            vecs++;
            if ({sdram_cke, pin_cmd, sdram_addr} !== {1'b1, 4'b0010, 13'h0400}) begin
                errs++;
                $display("FAIL reset_release_init: cke=%b cmd=%b addr=%h want cke=1 cmd=0010 addr=0400",
                         sdram_cke, pin_cmd, sdram_addr);
            end
            tick();
        end
    endtask

    task automatic test_init_exit();
        flag_init_end = 1'b1;
        @(negedge sclk);
        vecs++;
        if (pin_cmd !== 4'b0010) begin
            errs++;
            $display("FAIL init_hold: cmd=%b want 0010", pin_cmd);
        end
        tick();
        @(negedge sclk);
        vecs++;
        if ({pin_cmd, sdram_addr, sdram_bank, en} !== {NOP, 13'h0, 2'h0, 3'b000}) begin
            errs++;
            $display("FAIL init_to_arbit: cmd=%b addr=%h bank=%h en=%b want NOP/0/0/000",
                     pin_cmd, sdram_addr, sdram_bank, en);
        end
        tick();
    endtask

    task automatic test_priority();
        ref_req = 1'b1; wr_req = 1'b1;
        aref_cmd = 4'b0001; aref_addr = 13'h0400;
        @(negedge sclk);
        vecs++;
        if (en !== 3'b100) begin
            errs++;
            $display("FAIL prio_ref_over_wr: en=%b want 100", en);
        end
        tick();
        ref_req = 1'b0;
        @(negedge sclk);
        vecs++;
        if ({pin_cmd, sdram_addr, en} !== {4'b0001, 13'h0400, 3'b000}) begin
            errs++;
            $display("FAIL prio_aref_bus: cmd=%b addr=%h en=%b want 0001/0400/000",
                     pin_cmd, sdram_addr, en);
        end
        flag_ref_end = 1'b1;
        tick();
        flag_ref_end = 1'b0;
        @(negedge sclk);
        vecs++;
        if ({pin_cmd, en} !== {NOP, 3'b010}) begin
            errs++;
            $display("FAIL prio_wr_after_ref: cmd=%b en=%b want 0111/010", pin_cmd, en);
        end
        tick();
        wr_req = 1'b0;
        flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
    endtask

    task automatic test_write();
        wr_req = 1'b1; wr_data = 16'hA5A5;
        wr_cmd = 4'b0100; wr_addr = 13'h0123; wr_bank = 2'd2;
        @(negedge sclk);
        vecs++;
        if ({en, sdram_dq_oe} !== {3'b010, 1'b0}) begin
            errs++;
            $display("FAIL write_grant: en=%b oe=%b want 010/0", en, sdram_dq_oe);
        end
        tick();
        wr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sclk);
            vecs++;
            if ({sdram_dq_oe, sdram_dq_out, pin_cmd, sdram_addr, sdram_bank, en}
                !== {1'b1, 16'hA5A5, 4'b0100, 13'h0123, 2'd2, 3'b000}) begin
                errs++;
                $display("FAIL write_burst: oe=%b dq=%h cmd=%b addr=%h bank=%h en=%b want 1/a5a5/0100/0123/2/000",
                         sdram_dq_oe, sdram_dq_out, pin_cmd, sdram_addr, sdram_bank, en);
            end
            tick();
        end
        flag_wr_end = 1'b1;
        @(negedge sclk);
        vecs++;
        if (sdram_dq_oe !== 1'b1) begin
            errs++;
            $display("FAIL write_end_cycle: oe=%b want 1", sdram_dq_oe);
        end
        tick();
        flag_wr_end = 1'b0;
        @(negedge sclk);
        vecs++;
        if ({sdram_dq_oe, sdram_dq_out, pin_cmd} !== {1'b0, 16'h0, NOP}) begin
            errs++;
            $display("FAIL write_release: oe=%b dq=%h cmd=%b want 0/0000/0111",
                     sdram_dq_oe, sdram_dq_out, pin_cmd);
        end
        tick();
    endtask

    task automatic test_read_stray();
        rd_req = 1'b1; rd_cmd = 4'b0101;
        rd_addr = 13'h0ABC; rd_bank = 2'd1;
        @(negedge sclk);
        vecs++;
        if (en !== 3'b001) begin
            errs++;
            $display("FAIL read_grant: en=%b want 001", en);
        end
        tick();
        rd_req = 1'b0;
        flag_wr_end = 1'b1; flag_ref_end = 1'b1;
        @(negedge sclk);
        vecs++;
        if ({pin_cmd, sdram_addr, sdram_bank} !== {4'b0101, 13'h0ABC, 2'd1}) begin
            errs++;
            $display("FAIL read_bus: cmd=%b addr=%h bank=%h want 0101/0abc/1",
                     pin_cmd, sdram_addr, sdram_bank);
        end
        tick();
        flag_wr_end = 1'b0; flag_ref_end = 1'b0;
        @(negedge sclk);
        vecs++;
        if (pin_cmd !== 4'b0101) begin
            errs++;
            $display("FAIL read_stray_ignored: cmd=%b want 0101", pin_cmd);
        end
        flag_rd_end = 1'b1;
        tick();
        flag_rd_end = 1'b0;
        @(negedge sclk);
        vecs++;
        if ({pin_cmd, busy_err} !== {NOP, 1'b0}) begin
            errs++;
            $display("FAIL read_end: cmd=%b err=%b want 0111/0", pin_cmd, busy_err);
        end
        tick();
    endtask

    task automatic test_watchdog();
        rd_req = 1'b1;
        @(negedge sclk);
        tick();
        rd_req = 1'b0;
        for (int i = 0; i <= BMAX; i++) begin
            @(negedge sclk);
            vecs++;
            if ({pin_cmd, busy_err} !== {4'b0101, 1'b0}) begin
                errs++;
                $display("FAIL wdog_hold cyc %0d: cmd=%b err=%b want 0101/0", i, pin_cmd, busy_err);
            end
            tick();
        end
        @(negedge sclk);
        vecs++;
        if ({pin_cmd, busy_err} !== {NOP, 1'b1}) begin
            errs++;
            $display("FAIL wdog_abort: cmd=%b err=%b want 0111/1", pin_cmd, busy_err);
        end
        tick();
        @(negedge sclk);
        vecs++;
        if (busy_err !== 1'b0) begin
            errs++;
            $display("FAIL wdog_pulse_len: err=%b want 0", busy_err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        wr_req = 1'b1;
        @(negedge sclk);
        tick();
        wr_req = 1'b0;
        @(negedge sclk);
        vecs++;
        if (sdram_dq_oe !== 1'b1) begin
            errs++;
            $display("FAIL rstmid_in_write: oe=%b want 1", sdram_dq_oe);
        end
        #2;
        s_rst_n = 1'b0;
        flag_init_end = 1'b0;
        init_cmd = 4'b0010;
        m_own = O_INIT; m_up = 1'b0; m_err = 1'b0; m_held = 0;
        #1;
        vecs++;
        if ({pin_cmd, sdram_dq_oe, sdram_cke, en} !== {NOP, 1'b0, 1'b0, 3'b000}) begin
            errs++;
            $display("FAIL rstmid_immediate: cmd=%b oe=%b cke=%b en=%b want 0111/0/0/000",
                     pin_cmd, sdram_dq_oe, sdram_cke, en);
        end
        @(negedge sclk);
        s_rst_n = 1'b1;
        tick();
        @(negedge sclk);
        vecs++;
        if ({pin_cmd, sdram_cke} !== {4'b0010, 1'b1}) begin
            errs++;
            $display("FAIL rstmid_init: cmd=%b cke=%b want 0010/1", pin_cmd, sdram_cke);
        end
        flag_init_end = 1'b1;
        tick();
        @(negedge sclk);
        vecs++;
        if (pin_cmd !== NOP) begin
            errs++;
            $display("FAIL rstmid_arbit: cmd=%b want 0111", pin_cmd);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            ref_req = ($urandom_range(0, 7) == 0);
            wr_req = ($urandom_range(0, 3) == 0);
            rd_req = ($urandom_range(0, 3) == 0);
            flag_ref_end = ($urandom_range(0, 11) == 0);
            flag_wr_end = ($urandom_range(0, 11) == 0);
            flag_rd_end = ($urandom_range(0, 11) == 0);
            aref_cmd = 4'($urandom); wr_cmd = 4'($urandom);
            rd_cmd = 4'($urandom); init_cmd = 4'($urandom);
            aref_addr = 13'($urandom); wr_addr = 13'($urandom);
            rd_addr = 13'($urandom); init_addr = 13'($urandom);
            wr_bank = 2'($urandom); rd_bank = 2'($urandom);
            wr_data = 16'($urandom);
            @(negedge sclk);
            expect_pins();
            vecs++;
            if ({pin_cmd, sdram_addr, sdram_bank, sdram_dq_oe, sdram_dq_out, en}
                !== {e_cmd, e_addr, e_bank, e_oe, e_dq, e_en}) begin
                errs++;
                $display("FAIL random_pins cyc %0d: cmd=%b addr=%h bank=%h oe=%b dq=%h en=%b want %b %h %h %b %h %b",
                         i, pin_cmd, sdram_addr, sdram_bank, sdram_dq_oe, sdram_dq_out, en,
                         e_cmd, e_addr, e_bank, e_oe, e_dq, e_en);
            end
            vecs++;
            if ({sdram_cke, busy_err} !== {m_up, m_err}) begin
                errs++;
                $display("FAIL random_status cyc %0d: cke=%b err=%b want %b %b",
                         i, sdram_cke, busy_err, m_up, m_err);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_init_exit();
        test_priority();
        test_write();
        test_read_stray();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
